// File: rtl/alu_arb_pkg.sv
// alu_arb_pkg: shared types and default parameters for the ALU request arbiter.
package alu_arb_pkg;
  localparam int N_REQ_DEF = 4;
  localparam int DATA_W_DEF = 8;
  localparam int OP_W_DEF = 2;
  localparam int ALU_LATENCY_DEF = 1;
  typedef enum logic [1:0] {IDLE, BUSY, RESP} arb_state_e;
  typedef enum logic [1:0] {ADD = 2'd0, SUB = 2'd1, AND = 2'd2, OR = 2'd3} alu_op_e;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request at or after ptr.
module rr_arbiter #(
  parameter int N_REQ = 4,
  localparam int IW = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [IW-1:0]    idx,
  output logic             any
);
  logic [IW-1:0] w_j;
  // Scan from the farthest offset down so the nearest valid index wins.
  always_comb begin
    idx = '0;
    any = 1'b0;
    w_j = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      w_j = IW'((int'(ptr) + k) % N_REQ);
      if (req[w_j]) begin
        idx = w_j;
        any = 1'b1;
      end
    end
    gnt = any ? N_REQ'(1) << idx : '0;
  end
endmodule

// File: rtl/alu_req_arbiter.sv
// alu_req_arbiter: shares one registered ALU among N_REQ requesters round-robin and
// returns each result, tagged with the requester id, on one response channel.
module alu_req_arbiter
  import alu_arb_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int OP_W = OP_W_DEF,
  parameter int ALU_LATENCY = ALU_LATENCY_DEF,
  localparam int IW = $clog2(N_REQ)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req_valid,
  output logic [N_REQ-1:0]        req_ready,
  input  logic [N_REQ*DATA_W-1:0] req_a,
  input  logic [N_REQ*DATA_W-1:0] req_b,
  input  logic [N_REQ*OP_W-1:0]   req_op,
  output logic [DATA_W-1:0]       alu_a_o,
  output logic [DATA_W-1:0]       alu_b_o,
  output logic [OP_W-1:0]         alu_op_o,
  input  logic [DATA_W-1:0]       alu_result_i,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_W-1:0]       rsp_data,
  output logic [IW-1:0]           rsp_id,
  output logic                    busy_o
);
  arb_state_e r_state, w_next;
  logic [IW-1:0] r_ptr, w_idx;
  logic [2:0] r_cnt;
  logic [N_REQ-1:0] w_gnt;
  logic w_any, w_take;
  logic [DATA_W-1:0] w_a [N_REQ];
  logic [DATA_W-1:0] w_b [N_REQ];
  logic [OP_W-1:0] w_op [N_REQ];
  for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
    assign w_a[i] = req_a[i*DATA_W +: DATA_W];
    assign w_b[i] = req_b[i*DATA_W +: DATA_W];
    assign w_op[i] = req_op[i*OP_W +: OP_W];
  end
  rr_arbiter #(.N_REQ(N_REQ)) u_rr (
    .req(req_valid),
    .ptr(r_ptr),
    .gnt(w_gnt),
    .idx(w_idx),
    .any(w_any)
  );
  assign w_take = (r_state == IDLE) && w_any;
  assign req_ready = (r_state == IDLE) ? w_gnt : '0;
  assign rsp_valid = r_state == RESP;
  assign busy_o = r_state != IDLE;
  always_comb begin
    w_next = r_state;
    if (w_take) w_next = BUSY;
    else if (r_state == BUSY && r_cnt == '0) w_next = RESP;
    else if (rsp_valid && rsp_ready) w_next = IDLE;
  end
  // The counter starts at ALU_LATENCY, so BUSY spans ALU_LATENCY+1 cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_ptr <= '0;
      r_cnt <= '0;
      alu_a_o <= '0;
      alu_b_o <= '0;
      alu_op_o <= '0;
      rsp_data <= '0;
      rsp_id <= '0;
    end else begin
      r_state <= w_next;
      if (w_take) begin
        alu_a_o <= w_a[w_idx];
        alu_b_o <= w_b[w_idx];
        alu_op_o <= w_op[w_idx];
        rsp_id <= w_idx;
        r_ptr <= (int'(w_idx) == N_REQ - 1) ? '0 : w_idx + 1'b1;
        r_cnt <= 3'(ALU_LATENCY);
      end else if (r_state == BUSY) begin
        r_cnt <= r_cnt - 1'b1;
        if (r_cnt == '0) rsp_data <= alu_result_i;
      end
    end
  end
endmodule
